// File: rtl/ex_stage.sv
// ex_stage: execute stage of the in-order pipeline.
// Registers the ID->EX bus, computes the ALU result combinationally and
// forms the EX->MEM bus, the ID bypass bus and the data SRAM request.
// Optional feature macro EX_DIV_EN: multi-cycle restoring divider (DIV/DIVU)
// with HI register. When EX_DIV_EN is undefined, div_op is ignored,
// stallreq_ex is 0 and HI (and MFHI) read 0.
module ex_stage #(
  parameter int unsigned ID_TO_EX_WD  = 152,
  parameter int unsigned EX_TO_MEM_WD = 82,
  parameter int unsigned StallBus     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_ex,
  output logic [31:0]             hi_o
);

  localparam int unsigned XW    = 32;
  localparam int unsigned CNT_W = 5;

  typedef struct packed {
    logic [5:0]    ld_st_op;
    logic [XW-1:0] pc;
    logic [3:0]    alu_op;
    logic [1:0]    div_op;
    logic          data_ram_en;
    logic [3:0]    data_ram_wen;
    logic          sel_rf_res;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [XW-1:0] src1;
    logic [XW-1:0] src2;
    logic [XW-1:0] store_data;
  } id_ex_t;

  typedef struct packed {
    logic [5:0]    ld_st_op;
    logic [XW-1:0] pc;
    logic          data_ram_en;
    logic [3:0]    data_ram_wen;
    logic          sel_rf_res;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [XW-1:0] ex_result;
  } ex_mem_t;

  id_ex_t        id_r;
  ex_mem_t       mem_s;
  logic          ld_en;
  logic          bubble;
  logic [XW-1:0] alu_res;
  logic [XW-1:0] ex_result;
  logic [XW-1:0] hi_val;
  logic [4:0]    sh;

  // stall[2] is this stage, stall[3] the MEM stage; other bits are for earlier stages
  logic unused_stall;
  assign unused_stall = ^{stall[StallBus-1:4], stall[1:0]};

  assign ld_en  = ~stall[2];
  assign bubble = stall[2] & ~stall[3];
  assign sh     = id_r.src1[4:0];

  // Input register: bubble when EX holds but MEM moves on, load when EX advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_r <= '0;
    end else if (bubble) begin
      id_r <= '0;
    end else if (ld_en) begin
      id_r <= id_to_ex_bus;
    end
  end

  // ALU on the registered operands; shifts use src1[4:0] as amount on src2
  always_comb begin
    alu_res = '0;
    case (id_r.alu_op)
      4'd0:    alu_res = id_r.src1 + id_r.src2;
      4'd1:    alu_res = id_r.src1 - id_r.src2;
      4'd2:    alu_res = id_r.src1 & id_r.src2;
      4'd3:    alu_res = id_r.src1 | id_r.src2;
      4'd4:    alu_res = id_r.src1 ^ id_r.src2;
      4'd5:    alu_res = ~(id_r.src1 | id_r.src2);
      4'd6:    alu_res = {31'd0, $signed(id_r.src1) < $signed(id_r.src2)};
      4'd7:    alu_res = {31'd0, id_r.src1 < id_r.src2};
      4'd8:    alu_res = id_r.src2 << sh;
      4'd9:    alu_res = id_r.src2 >> sh;
      4'd10:   alu_res = XW'($signed(id_r.src2) >>> sh);
      4'd11:   alu_res = {id_r.src2[15:0], 16'd0};
      4'd12:   alu_res = hi_val;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  div_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [XW-1:0]    dvd, dvd_n;
  logic [XW-1:0]    dvs, dvs_n;
  logic [XW-1:0]    rem, rem_n;
  logic [XW-1:0]    quo, quo_n;
  logic [XW-1:0]    q_res, q_res_n;
  logic [XW-1:0]    hi, hi_n;
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic             div_req;
  logic             div_sgn;
  logic [XW:0]      part;
  logic [XW:0]      diff;
  logic [XW-1:0]    rem_i;
  logic [XW-1:0]    quo_i;
  logic [XW-1:0]    abs1;
  logic [XW-1:0]    abs2;

  assign div_req = id_r.div_op[1];
  assign div_sgn = ~id_r.div_op[0];
  assign abs1    = (div_sgn && id_r.src1[XW-1]) ? (~id_r.src1 + XW'(1)) : id_r.src1;
  assign abs2    = (div_sgn && id_r.src2[XW-1]) ? (~id_r.src2 + XW'(1)) : id_r.src2;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    part = {rem, dvd[XW-1]};
    diff = part - {1'b0, dvs};
    if (!diff[XW]) begin
      rem_i = diff[XW-1:0];
      quo_i = {quo[XW-2:0], 1'b1};
    end else begin
      rem_i = part[XW-1:0];
      quo_i = {quo[XW-2:0], 1'b0};
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Divider next-state, datapath next values and EX self-stall request
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    dvd_n       = dvd;
    dvs_n       = dvs;
    rem_n       = rem;
    quo_n       = quo;
    q_res_n     = q_res;
    hi_n        = hi;
    neg_q_n     = neg_q;
    neg_r_n     = neg_r;
    stallreq_ex = 1'b0;
    case (state)
      S_IDLE: begin
        if (div_req) begin
          stallreq_ex = 1'b1;
          if (id_r.src2 == '0) begin
            q_res_n = '1;
            hi_n    = id_r.src1;
            state_n = S_DONE;
          end else begin
            dvd_n   = abs1;
            dvs_n   = abs2;
            rem_n   = '0;
            quo_n   = '0;
            cnt_n   = '0;
            neg_q_n = div_sgn & (id_r.src1[XW-1] ^ id_r.src2[XW-1]);
            neg_r_n = div_sgn & id_r.src1[XW-1];
            state_n = S_RUN;
          end
        end
      end
      S_RUN: begin
        stallreq_ex = 1'b1;
        dvd_n       = {dvd[XW-2:0], 1'b0};
        rem_n       = rem_i;
        quo_n       = quo_i;
        cnt_n       = cnt + CNT_W'(1);
        if (cnt == CNT_W'(31)) begin
          q_res_n = neg_q ? (~quo_i + XW'(1)) : quo_i;
          hi_n    = neg_r ? (~rem_i + XW'(1)) : rem_i;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (ld_en) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Divider working registers, final quotient and HI
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      q_res <= '0;
      hi    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      dvd   <= dvd_n;
      dvs   <= dvs_n;
      rem   <= rem_n;
      quo   <= quo_n;
      q_res <= q_res_n;
      hi    <= hi_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
    end
  end

  assign hi_val = hi;

  // A divide replaces the ALU result; it is only meaningful once DONE
  always_comb begin
    ex_result = alu_res;
    if (div_req) begin
      ex_result = (state == S_DONE) ? q_res : '0;
    end
  end
`else
  logic unused_div;
  assign unused_div  = ^id_r.div_op;
  assign stallreq_ex = 1'b0;
  assign hi_val      = '0;
  assign ex_result   = alu_res;
`endif

  // EX->MEM payload assembled from the registered bus and the stage result
  always_comb begin
    mem_s.ld_st_op     = id_r.ld_st_op;
    mem_s.pc           = id_r.pc;
    mem_s.data_ram_en  = id_r.data_ram_en;
    mem_s.data_ram_wen = id_r.data_ram_wen;
    mem_s.sel_rf_res   = id_r.sel_rf_res;
    mem_s.rf_we        = id_r.rf_we;
    mem_s.rf_waddr     = id_r.rf_waddr;
    mem_s.ex_result    = ex_result;
  end

  assign ex_to_mem_bus   = mem_s;
  assign ex_to_rf_bus    = {id_r.rf_we & ~stallreq_ex, id_r.rf_waddr, ex_result};
  assign data_sram_en    = id_r.data_ram_en;
  assign data_sram_wen   = id_r.data_ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = id_r.store_data;
  assign hi_o            = hi_val;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven ALU/SRAM vectors plus hand-written stall,
// bubble, reset and (with EX_DIV_EN) divider sequences, scoreboard checked.
module tb_ex_stage;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  dop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic        ren;
    logic [3:0]  rwen;
    logic        rwe;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [81:0] mem;
    logic [37:0] rf;
    logic        sen;
    logic [3:0]  swen;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic        streq;
    logic [31:0] hi;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [151:0] id_bus;
  logic [81:0]  mem_bus;
  logic [37:0]  rf_bus;
  logic         sen;
  logic [3:0]   swen;
  logic [31:0]  saddr;
  logic [31:0]  swdata;
  logic         streq;
  logic [31:0]  hi_o;

  exp_t        sb[$];
  vec_t        tv[17];
  int          n_vec;
  int          n_bad;
  logic [31:0] hi_m;

  ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .id_to_ex_bus   (id_bus),
    .ex_to_mem_bus  (mem_bus),
    .ex_to_rf_bus   (rf_bus),
    .data_sram_en   (sen),
    .data_sram_wen  (swen),
    .data_sram_addr (saddr),
    .data_sram_wdata(swdata),
    .stallreq_ex    (streq),
    .hi_o           (hi_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic vec_t mkv(input logic [3:0] op, input logic [1:0] dop,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] sd, input logic ren,
                               input logic [3:0] rwen, input logic rwe,
                               input logic [31:0] res);
    vec_t v;
    v.op = op; v.dop = dop; v.a = a; v.b = b; v.sd = sd;
    v.ren = ren; v.rwen = rwen; v.rwe = rwe; v.res = res;
    return v;
  endfunction

  function automatic logic [151:0] mk_bus(input int i, input vec_t v);
    logic [5:0]  ls;
    logic [31:0] pc;
    logic        sel;
    logic [4:0]  wa;
    ls  = 6'(i);
    pc  = 32'hBFC0_0000 + 32'(i * 4);
    sel = 1'(i);
    wa  = 5'(i + 1);
    return {ls, pc, v.op, v.dop, v.ren, v.rwen, sel, v.rwe, wa, v.a, v.b, v.sd};
  endfunction

  function automatic exp_t mk_exp(input int i, input vec_t v, input logic [31:0] h,
                                  input logic sr);
    exp_t e;
    logic [5:0]  ls;
    logic [31:0] pc;
    logic        sel;
    logic [4:0]  wa;
    ls  = 6'(i);
    pc  = 32'hBFC0_0000 + 32'(i * 4);
    sel = 1'(i);
    wa  = 5'(i + 1);
    e.mem    = {ls, pc, v.ren, v.rwen, sel, v.rwe, wa, v.res};
    e.rf     = {v.rwe & ~sr, wa, v.res};
    e.sen    = v.ren;
    e.swen   = v.rwen;
    e.saddr  = v.res;
    e.swdata = v.sd;
    e.streq  = sr;
    e.hi     = h;
    return e;
  endfunction

  function automatic exp_t zero_exp(input logic [31:0] h);
    exp_t e;
    e.mem = '0; e.rf = '0; e.sen = 1'b0; e.swen = '0;
    e.saddr = '0; e.swdata = '0; e.streq = 1'b0; e.hi = h;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [81:0] act, input logic [81:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got empty scoreboard want entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".mem"},    mem_bus, e.mem);
    chk({tag, ".rf"},     rf_bus,  e.rf);
    chk({tag, ".sen"},    sen,     e.sen);
    chk({tag, ".swen"},   swen,    e.swen);
    chk({tag, ".saddr"},  saddr,   e.saddr);
    chk({tag, ".swdata"}, swdata,  e.swdata);
    chk({tag, ".streq"},  streq,   e.streq);
    chk({tag, ".hi"},     hi_o,    e.hi);
  endtask

  task automatic apply(input int i, input vec_t v, input string tag);
    @(negedge clk);
    stall  = '0;
    id_bus = mk_bus(i, v);
    sb.push_back(mk_exp(i, v, hi_m, 1'b0));
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

`ifdef EX_DIV_EN
  task automatic run_div(input int i, input logic [1:0] dop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q,
                         input logic [31:0] r, input int lat, input string tag);
    vec_t v;
    exp_t e;
    int   cyc;
    v = mkv(4'd0, dop, a, b, 32'h0, 1'b0, 4'h0, 1'b1, q);
    @(negedge clk);
    stall  = '0;
    id_bus = mk_bus(i, v);
    hi_m   = r;
    e      = mk_exp(i, v, r, 1'b0);
    e.saddr = a + b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    stall = 6'b001111;
    chk({tag, ".stallreq_c0"}, streq, 1'b1);
    chk({tag, ".byp_we_c0"}, rf_bus[37], 1'b0);
    cyc = 0;
    while (streq === 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".latency"}, 82'(cyc), 82'(lat));
    pop_check(tag);
    sb.push_back(e);
    repeat (2) @(posedge clk);
    #1;
    pop_check({tag, ".held"});
  endtask
`endif

  initial begin
    vec_t v;
    n_vec = 0;
    n_bad = 0;
    hi_m  = '0;

    tv[0]  = mkv(4'd0,  2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 4'h0, 1'b1, 32'h8000_0000);
    tv[1]  = mkv(4'd1,  2'b00, 32'h0000_0005, 32'h0000_0007, 32'h0, 1'b0, 4'h0, 1'b1, 32'hFFFF_FFFE);
    tv[2]  = mkv(4'd2,  2'b00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 1'b0, 4'h0, 1'b1, 32'h00F0_1200);
    tv[3]  = mkv(4'd3,  2'b00, 32'hF000_0000, 32'h0000_000F, 32'h0, 1'b0, 4'h0, 1'b1, 32'hF000_000F);
    tv[4]  = mkv(4'd4,  2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 1'b0, 4'h0, 1'b1, 32'hF0F0_0F0F);
    tv[5]  = mkv(4'd5,  2'b00, 32'h0000_FFFF, 32'h00FF_0000, 32'h0, 1'b0, 4'h0, 1'b1, 32'hFF00_0000);
    tv[6]  = mkv(4'd6,  2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0000_0001);
    tv[7]  = mkv(4'd7,  2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0000_0000);
    tv[8]  = mkv(4'd8,  2'b00, 32'h0000_0024, 32'h8000_0001, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0000_0010);
    tv[9]  = mkv(4'd9,  2'b00, 32'h0000_0004, 32'h8000_0000, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0800_0000);
    tv[10] = mkv(4'd10, 2'b00, 32'h0000_0004, 32'h8000_0000, 32'h0, 1'b0, 4'h0, 1'b1, 32'hF800_0000);
    tv[11] = mkv(4'd11, 2'b00, 32'h0000_DEAD, 32'h0000_1234, 32'h0, 1'b0, 4'h0, 1'b1, 32'h1234_0000);
    tv[12] = mkv(4'd12, 2'b00, 32'h0000_0001, 32'h0000_0002, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0000_0000);
    tv[13] = mkv(4'd13, 2'b00, 32'h0000_0003, 32'h0000_0004, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0000_0000);
    tv[14] = mkv(4'd15, 2'b00, 32'h0000_0003, 32'h0000_0004, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0000_0000);
    tv[15] = mkv(4'd0,  2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0000_0001);
    tv[16] = mkv(4'd0,  2'b00, 32'h0000_0100, 32'h0000_0004, 32'h0000_00A5, 1'b1, 4'hF, 1'b0, 32'h0000_0104);

    // reset state: bus present but register must stay clear
    rst    = 1'b0;
    stall  = '0;
    id_bus = mk_bus(1, tv[1]);
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(zero_exp(32'h0));
    pop_check("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(i, tv[i], $sformatf("v%0d", i));
    end

    // EX and MEM both held: register keeps the previous instruction
    apply(2, tv[2], "pre_hold");
    @(negedge clk);
    stall  = 6'b001100;
    id_bus = mk_bus(5, tv[5]);
    sb.push_back(mk_exp(2, tv[2], hi_m, 1'b0));
    @(posedge clk);
    #1;
    pop_check("hold");

    // EX held while MEM advances: bubble
    @(negedge clk);
    stall  = 6'b000100;
    id_bus = mk_bus(6, tv[6]);
    sb.push_back(zero_exp(hi_m));
    @(posedge clk);
    #1;
    pop_check("bubble");

`ifdef EX_DIV_EN
    run_div(20, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_m7_2");
    apply(40, mkv(4'd12, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, hi_m), "mfhi_a");
    run_div(21, 2'b11, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 1, "divu_5_0");
    apply(41, mkv(4'd12, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, hi_m), "mfhi_b");

    // asynchronous reset during RUN iteration 10 abandons the divide
    v = mkv(4'd0, 2'b11, 32'd100, 32'd7, 32'h0, 1'b0, 4'h0, 1'b1, 32'd14);
    @(negedge clk);
    stall  = '0;
    id_bus = mk_bus(22, v);
    @(posedge clk);
    #1;
    stall = 6'b001111;
    chk("rstdiv.stallreq_c0", streq, 1'b1);
    repeat (11) @(posedge clk);
    #2;
    rst  = 1'b0;
    hi_m = '0;
    #1;
    sb.push_back(zero_exp(32'h0));
    pop_check("rst_mid_div");
    @(negedge clk);
    rst = 1'b1;

    run_div(22, 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_100_7");
    run_div(23, 2'b10, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 33, "div_100_m7");
    run_div(24, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33, "div_min_m1");
    apply(42, mkv(4'd1, 2'b00, 32'd1, 32'd1, 32'h0, 1'b0, 4'h0, 1'b1, 32'd0), "after_div");
`else
    // without the divider a divide op is plain ALU work and never stalls
    apply(30, mkv(4'd0, 2'b10, 32'd7, 32'd2, 32'h0, 1'b0, 4'h0, 1'b1, 32'd9), "div_ignored");
    @(posedge clk);
    #1;
    chk("div_ignored.streq_later", streq, 1'b0);
    chk("div_ignored.hi_later", hi_o, 32'h0);
    apply(31, mkv(4'd12, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 32'h0), "mfhi_nodiv");

    apply(2, tv[2], "pre_rst");
    #3;
    rst = 1'b0;
    #1;
    sb.push_back(zero_exp(32'h0));
    pop_check("async_rst");
    @(negedge clk);
    rst = 1'b1;
    apply(0, tv[0], "post_rst");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters (macros): ID_TO_EX_WD, default 152, ID->EX bus width; EX_TO_MEM_WD, default 82, EX->MEM bus width; StallBus, default 6, stall vector width.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 stall  in  StallBus  per-stage hold; stall[2] = EX, stall[3] = MEM; Stop=1, NoStop=0.
REQ-005 id_to_ex_bus  in  152  {ld_st_op[6], pc[32], alu_op[4], div_op[2], data_ram_en, data_ram_wen[4], sel_rf_res, rf_we, rf_waddr[5], src1[32], src2[32], store_data[32]}, MSB first.
REQ-006 ex_to_mem_bus  out  82  {ld_st_op[6], pc[32], data_ram_en, data_ram_wen[4], sel_rf_res, rf_we, rf_waddr[5], ex_result[32]}, MSB first.
REQ-007 ex_to_rf_bus  out  38  {we, waddr[5], wdata[32]}; ID-stage bypass.
REQ-008 data_sram_en / data_sram_wen[4] / data_sram_addr[32] / data_sram_wdata[32]  out  data SRAM request.
REQ-009 stallreq_ex  out  1  EX hold request to the stall controller.
REQ-010 hi_o  out  32  current HI register (divide remainder).

Function
REQ-011 Input register: if stall[2]=Stop and stall[3]=NoStop, load all-zero bubble; else if stall[2]=NoStop, load id_to_ex_bus; else hold.
REQ-012 ALU result from the registered bus, combinational: alu_op 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL, 9 SRL, 10 SRA (shift src2 by src1[4:0]), 11 LUI = src2<<16, 12 MFHI = HI; 13-15 yield 0; all 32-bit modulo arithmetic.
REQ-013 SRAM request = data_ram_en, data_ram_wen, address = ALU result, wdata = store_data; a bubble drives all zeros.
REQ-014 div_op: 00 none, 10 DIV signed, 11 DIVU, 01 treated as none; a divide overrides the ALU result with the quotient and writes the remainder to HI.
REQ-015 Divider FSM states IDLE, RUN, DONE; restoring, 1 quotient bit per cycle.
REQ-016 IDLE with a divide in the register: latch |src1|,|src2| (raw for DIVU), counter=0, go to RUN; divisor 0 goes straight to DONE with quotient 0xFFFFFFFF, remainder = src1.
REQ-017 RUN: one iteration per cycle; after iteration 31 go to DONE; signed results: quotient negated if sign differs, remainder takes src1 sign.
REQ-018 stallreq_ex = 1 in IDLE-with-divide and in RUN; 0 in DONE and otherwise. Latency: divide enters EX at cycle 0, result visible on buses at cycle 33.
REQ-019 DONE: hold result; HI updated once on the DONE entry edge; return to IDLE when the input register loads (stall[2]=NoStop).
REQ-020 ex_to_rf_bus.we = rf_we and not stallreq_ex; waddr/wdata mirror ex_to_mem_bus.
REQ-021 A bubble loaded while in RUN is not possible (EX self-stalled); downstream stall in DONE holds the result unchanged.

Reset
REQ-022 rst low asynchronously clears the input register, HI, divider state, and counter to 0/IDLE; all outputs read 0; a divide in progress is abandoned.

Configuration
REQ-023 EX_DIV_EN defined: divider per REQ-014..019. Undefined: no divider logic; div_op ignored, stallreq_ex tied 0, HI holds 0, MFHI returns 0.

Verification
REQ-024 ADDU src1=0x7FFFFFFF, src2=1 -> ex_result 0x80000000, same cycle as register load.
REQ-025 SW data_ram_en=1, wen=0xF, src1=0x100, src2=4, store_data=0xA5 -> addr 0x104, wdata 0xA5, sram_en=1.
REQ-026 DIV -7/2 -> stallreq_ex high 33 cycles, quotient 0xFFFFFFFD, HI 0xFFFFFFFF; bypass we low while stalled.
REQ-027 DIVU 5/0 -> DONE next cycle, quotient 0xFFFFFFFF, HI 5.
REQ-028 rst pulsed low at RUN iteration 10 -> all outputs 0 immediately, stallreq_ex 0, next divide completes normally.
REQ-029 stall[2]=1, stall[3]=0 -> bubble: ex_to_mem_bus all zero next cycle.
